char_scan_display: RTL

CHAR_SCAN_DISPLAY -- requirements
Module: char_scan_display

---
 rtl/char_scan_display.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/char_scan_display.sv
// char_scan_display: multiplexed 7-segment scanner that shows a window of a character buffer.
// Define CHAR_SCAN_SCROLL_EN to build the scroll state machine that walks the window through the buffer.
module char_scan_display #(
  parameter  int NUM_DIGITS  = 4,
  parameter  int BUF_DEPTH   = 8,
  parameter  int REFRESH_DIV = 50000,
  parameter  int SCROLL_DIV  = 64,
  localparam int AW          = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [4:0]            wr_char,
  input  logic                  scroll_en,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_tick
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [RW-1:0]         refreshCnt_q, refreshCnt_d;
  logic [DW-1:0]         digitIdx_q, digitIdx_d;
  logic                  slotTick;
  logic [4:0]            charBuf_q [BUF_DEPTH];
  logic [AW-1:0]         offset;
  logic [AW-1:0]         entryIdx;
  logic [4:0]            curChar;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0:    s = 7'b0111111;
      4'h1:    s = 7'b0000110;
      4'h2:    s = 7'b1011011;
      4'h3:    s = 7'b1001111;
      4'h4:    s = 7'b1100110;
      4'h5:    s = 7'b1101101;
      4'h6:    s = 7'b1111101;
      4'h7:    s = 7'b0000111;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1101111;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b1111100;
      4'hC:    s = 7'b0111001;
      4'hD:    s = 7'b1011110;
      4'hE:    s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  assign slotTick   = (refreshCnt_q == RW'(REFRESH_DIV - 1));
  assign frame_tick = slotTick && (digitIdx_q == DW'(NUM_DIGITS - 1));

  always_comb begin
    refreshCnt_d = slotTick ? '0 : refreshCnt_q + RW'(1);
    digitIdx_d   = digitIdx_q;
    if (slotTick) begin
      digitIdx_d = frame_tick ? '0 : digitIdx_q + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refreshCnt_q <= '0;
      digitIdx_q   <= '0;
    end else begin
      refreshCnt_q <= refreshCnt_d;
      digitIdx_q   <= digitIdx_d;
    end
  end

  // Masking keeps indices legal even for a single-entry buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        charBuf_q[i] <= 5'b10000;
      end
    end else if (wr_en) begin
      charBuf_q[wr_addr & AW'(BUF_DEPTH - 1)] <= wr_char;
    end
  end

`ifdef CHAR_SCAN_SCROLL_EN
  typedef enum logic {IDLE, RUN} scrollState_t;
  localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  scrollState_t  state_q, state_d;
  logic [FW-1:0] frameCnt_q, frameCnt_d;
  logic [AW-1:0] offset_q, offset_d;

  always_comb begin
    state_d    = state_q;
    frameCnt_d = frameCnt_q;
    offset_d   = offset_q;
    case (state_q)
      IDLE: begin
        if (scroll_en) state_d = RUN;
      end
      RUN: begin
        if (!scroll_en) begin
          state_d    = IDLE;
          frameCnt_d = '0;
        end else if (frame_tick) begin
          if (frameCnt_q == FW'(SCROLL_DIV - 1)) begin
            frameCnt_d = '0;
            offset_d   = (offset_q + AW'(1)) & AW'(BUF_DEPTH - 1);
          end else begin
            frameCnt_d = frameCnt_q + FW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      frameCnt_q <= '0;
      offset_q   <= '0;
    end else begin
      state_q    <= state_d;
      frameCnt_q <= frameCnt_d;
      offset_q   <= offset_d;
    end
  end

  assign offset = offset_q;
`else
  logic unusedScroll;
  assign unusedScroll = scroll_en | (SCROLL_DIV == 0);
  assign offset       = '0;
`endif

  // Offset entry lands on the leftmost digit; 32-bit wrap then truncation gives the modulo.
  always_comb begin
    entryIdx = AW'(32'(offset) + 32'(NUM_DIGITS - 1) - 32'(digitIdx_q)) & AW'(BUF_DEPTH - 1);
    curChar  = charBuf_q[entryIdx];
    seg_d    = curChar[4] ? 7'b0000000 : glyph(curChar[3:0]);
    an_d     = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_d[i] = (DW'(i) != digitIdx_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '0;
      an_q  <= '1;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule
